// File: rtl/pipeline_pkg.sv
// Shared decode helpers for the 5-stage pipeline hazard logic: opcode constants, the NOP
// encoding and per-instruction register/flag read/write classification.
package pipeline_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_MOV  = 5'b01001;
   localparam logic [4:0] OP_LSL  = 5'b01010;
   localparam logic [4:0] OP_LSR  = 5'b01011;
   localparam logic [4:0] OP_ASR  = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b01101;
   localparam logic [4:0] OP_LD   = 5'b01110;
   localparam logic [4:0] OP_ST   = 5'b01111;
   localparam logic [4:0] OP_BEQ  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_B    = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;

   localparam logic [31:0] NOP_IR = 32'h6800_0000;
   localparam logic [3:0]  RA_REG = 4'd15;

   typedef enum logic {StIdle, StFlush} br_state_e;

   function automatic logic [4:0] opcode(input logic [31:0] ir);
      return ir[31:27];
   endfunction

   function automatic logic writes_rd(input logic [31:0] ir);
      return opcode(ir) inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
                                OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_CALL};
   endfunction

   // call links through r15; every other writer targets the rd field.
   function automatic logic [3:0] dest_reg(input logic [31:0] ir);
      return (opcode(ir) == OP_CALL) ? RA_REG : ir[25:22];
   endfunction

   function automatic logic reads_rs1(input logic [31:0] ir);
      return opcode(ir) inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND,
                                OP_OR, OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_ST};
   endfunction

   function automatic logic reads_rs2(input logic [31:0] ir);
      return !ir[26] && (reads_rs1(ir) || (opcode(ir) inside {OP_NOT, OP_MOV}));
   endfunction

   function automatic logic writes_flags(input logic [31:0] ir);
      return opcode(ir) == OP_CMP;
   endfunction

   function automatic logic reads_flags(input logic [31:0] ir);
      return opcode(ir) inside {OP_BEQ, OP_BGT};
   endfunction

   // True when ir uses register r as a source operand (including st data and ret link).
   function automatic logic reads_reg(input logic [31:0] ir, input logic [3:0] r);
      logic hit;
      hit = 1'b0;
      if (reads_rs1(ir) && (ir[21:18] == r)) hit = 1'b1;
      if (reads_rs2(ir) && (ir[17:14] == r)) hit = 1'b1;
      if ((opcode(ir) == OP_ST) && (ir[25:22] == r)) hit = 1'b1;
      if ((opcode(ir) == OP_RET) && (r == RA_REG)) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/hazard_compare.sv
// Compares the OF-stage instruction against one older in-flight instruction and flags a
// dependency that requires a stall.
module hazard_compare
   import pipeline_pkg::*;
#(
   parameter bit LoadUseOnly = 1'b0,
   parameter bit IsExStage   = 1'b0
) (
   input  logic [31:0] of_ir_i,
   input  logic [31:0] older_ir_i,
   output logic        match_o
);

   logic reg_hit;
   logic flag_hit;

   always_comb begin
      reg_hit  = writes_rd(older_ir_i) && reads_reg(of_ir_i, dest_reg(older_ir_i));
      flag_hit = writes_flags(older_ir_i) && reads_flags(of_ir_i);
      if (LoadUseOnly) begin
         // With forwarding only a load still in EX cannot supply its result in time.
         match_o = IsExStage && (opcode(older_ir_i) == OP_LD) && reg_hit;
      end else begin
         match_o = reg_hit || flag_hit;
      end
   end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Data/branch interlock controller with saturating stall and flush counters.
// Define FORWARDING_EN to reduce data stalls to load-use hazards only.
module pipeline_interlock_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned BR_PENALTY = 2,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      OF_IR,
   input  logic [31:0]      EX_IR,
   input  logic [31:0]      MA_IR,
   input  logic [31:0]      RW_IR,
   input  logic             EX_isBranchTaken,
   output logic             isDataInterLock,
   output logic             isBranchInterLock,
   output logic             pc_write_en,
   output logic             if_of_write_en,
   output logic [CNT_W-1:0] data_stall_count,
   output logic [CNT_W-1:0] branch_flush_count
);

   localparam int unsigned       FlushW      = $clog2(BR_PENALTY + 1);
   localparam logic [FlushW-1:0] FlushReload = FlushW'(BR_PENALTY - 1);

`ifdef FORWARDING_EN
   localparam bit LoadUseOnly = 1'b1;
`else
   localparam bit LoadUseOnly = 1'b0;
`endif

   logic ex_match, ma_match, rw_match;
   logic data_hazard;
   logic branch_il;

   br_state_e         state_q, state_d;
   logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;

   hazard_compare #(
      .LoadUseOnly (LoadUseOnly),
      .IsExStage   (1'b1)
   ) u_cmp_ex (
      .of_ir_i    (OF_IR),
      .older_ir_i (EX_IR),
      .match_o    (ex_match)
   );

   hazard_compare #(
      .LoadUseOnly (LoadUseOnly),
      .IsExStage   (1'b0)
   ) u_cmp_ma (
      .of_ir_i    (OF_IR),
      .older_ir_i (MA_IR),
      .match_o    (ma_match)
   );

   hazard_compare #(
      .LoadUseOnly (LoadUseOnly),
      .IsExStage   (1'b0)
   ) u_cmp_rw (
      .of_ir_i    (OF_IR),
      .older_ir_i (RW_IR),
      .match_o    (rw_match)
   );

   assign data_hazard = ex_match || ma_match || rw_match;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      branch_il   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (EX_isBranchTaken) begin
               branch_il = 1'b1;
               if (BR_PENALTY > 1) begin
                  state_d     = StFlush;
                  flush_cnt_d = FlushReload;
               end
            end
         end
         StFlush: begin
            branch_il = 1'b1;
            if (EX_isBranchTaken) begin
               flush_cnt_d = FlushReload;
            end else if (flush_cnt_q <= FlushW'(1)) begin
               state_d     = StIdle;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - FlushW'(1);
            end
         end
         default: begin
            state_d     = StIdle;
            flush_cnt_d = '0;
         end
      endcase
   end

   // A flush wins over a data stall so the PC can load the branch target.
   always_comb begin
      isBranchInterLock = branch_il;
      isDataInterLock   = data_hazard && !branch_il;
      pc_write_en       = !isDataInterLock;
      if_of_write_en    = !isDataInterLock;

      data_cnt_d = data_cnt_q;
      br_cnt_d   = br_cnt_q;
      if (isDataInterLock && (data_cnt_q != '1)) data_cnt_d = data_cnt_q + CNT_W'(1);
      if (isBranchInterLock && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         flush_cnt_q <= '0;
         data_cnt_q  <= '0;
         br_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         data_cnt_q  <= data_cnt_d;
         br_cnt_q    <= br_cnt_d;
      end
   end

   assign data_stall_count   = data_cnt_q;
   assign branch_flush_count = br_cnt_q;

endmodule
